// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 decoding definitions: FSM state type and prefix/modifier codes.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    localparam logic [7:0] BRK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE = 8'hE0;
    localparam logic [7:0] LSHIFT   = 8'h12;
    localparam logic [7:0] RSHIFT   = 8'h59;
    localparam logic [7:0] CAPS     = 8'h58;

    // True for either Shift scancode.
    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == LSHIFT) || (code == RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational set-2 scancode to ASCII map for letters, digits, space and enter.
module ps2_keymap (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii,
    output logic       hit
);

    logic       is_letter;
    logic       is_digit;
    logic [4:0] letter_idx;
    logic [3:0] digit_idx;

    // Shifted glyphs of the top-row digits, indexed by digit value.
    function automatic logic [7:0] shifted_digit(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h29; // )
            4'd1:    return 8'h21; // !
            4'd2:    return 8'h40; // @
            4'd3:    return 8'h23; // #
            4'd4:    return 8'h24; // $
            4'd5:    return 8'h25; // %
            4'd6:    return 8'h5E; // ^
            4'd7:    return 8'h26; // &
            4'd8:    return 8'h2A; // *
            default: return 8'h28; // (
        endcase
    endfunction

    // Classify the code and resolve the final character from the modifier state.
    always_comb begin
        is_letter  = 1'b0;
        is_digit   = 1'b0;
        letter_idx = 5'd0;
        digit_idx  = 4'd0;
        ascii      = 8'h00;
        hit        = 1'b1;
        case (code)
            8'h1C: begin is_letter = 1'b1; letter_idx = 5'd0;  end
            8'h32: begin is_letter = 1'b1; letter_idx = 5'd1;  end
            8'h21: begin is_letter = 1'b1; letter_idx = 5'd2;  end
            8'h23: begin is_letter = 1'b1; letter_idx = 5'd3;  end
            8'h24: begin is_letter = 1'b1; letter_idx = 5'd4;  end
            8'h2B: begin is_letter = 1'b1; letter_idx = 5'd5;  end
            8'h34: begin is_letter = 1'b1; letter_idx = 5'd6;  end
            8'h33: begin is_letter = 1'b1; letter_idx = 5'd7;  end
            8'h43: begin is_letter = 1'b1; letter_idx = 5'd8;  end
            8'h3B: begin is_letter = 1'b1; letter_idx = 5'd9;  end
            8'h42: begin is_letter = 1'b1; letter_idx = 5'd10; end
            8'h4B: begin is_letter = 1'b1; letter_idx = 5'd11; end
            8'h3A: begin is_letter = 1'b1; letter_idx = 5'd12; end
            8'h31: begin is_letter = 1'b1; letter_idx = 5'd13; end
            8'h44: begin is_letter = 1'b1; letter_idx = 5'd14; end
            8'h4D: begin is_letter = 1'b1; letter_idx = 5'd15; end
            8'h15: begin is_letter = 1'b1; letter_idx = 5'd16; end
            8'h2D: begin is_letter = 1'b1; letter_idx = 5'd17; end
            8'h1B: begin is_letter = 1'b1; letter_idx = 5'd18; end
            8'h2C: begin is_letter = 1'b1; letter_idx = 5'd19; end
            8'h3C: begin is_letter = 1'b1; letter_idx = 5'd20; end
            8'h2A: begin is_letter = 1'b1; letter_idx = 5'd21; end
            8'h1D: begin is_letter = 1'b1; letter_idx = 5'd22; end
            8'h22: begin is_letter = 1'b1; letter_idx = 5'd23; end
            8'h35: begin is_letter = 1'b1; letter_idx = 5'd24; end
            8'h1A: begin is_letter = 1'b1; letter_idx = 5'd25; end
            8'h45: begin is_digit = 1'b1; digit_idx = 4'd0; end
            8'h16: begin is_digit = 1'b1; digit_idx = 4'd1; end
            8'h1E: begin is_digit = 1'b1; digit_idx = 4'd2; end
            8'h26: begin is_digit = 1'b1; digit_idx = 4'd3; end
            8'h25: begin is_digit = 1'b1; digit_idx = 4'd4; end
            8'h2E: begin is_digit = 1'b1; digit_idx = 4'd5; end
            8'h36: begin is_digit = 1'b1; digit_idx = 4'd6; end
            8'h3D: begin is_digit = 1'b1; digit_idx = 4'd7; end
            8'h3E: begin is_digit = 1'b1; digit_idx = 4'd8; end
            8'h46: begin is_digit = 1'b1; digit_idx = 4'd9; end
            8'h29:   ascii = 8'h20;
            8'h5A:   ascii = 8'h0D;
            default: hit   = 1'b0;
        endcase

        // Caps only folds letter case; digits follow Shift alone.
        if (is_letter) begin
            ascii = ((shift ^ caps) ? 8'h41 : 8'h61) + {3'b000, letter_idx};
        end else if (is_digit) begin
            ascii = shift ? shifted_digit(digit_idx) : (8'h30 + {4'b0000, digit_idx});
        end
    end

endmodule

// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scancode stream to ASCII decoder with modifier tracking,
// typematic repeat suppression and an emitted-character counter.
module ps2_ascii_decoder
    import ps2_pkg::*;
#(
    parameter int CNT_W         = 8,
    parameter int REPEAT_FILTER = 1,
    parameter int CAPS_EN       = 1
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [7:0]       scan_data,
    input  logic             scan_valid,
    output logic [7:0]       ascii,
    output logic             ascii_valid,
    output logic             key_down,
    output logic [CNT_W-1:0] key_count,
    output logic             shift,
    output logic             caps
);

    ps2_state_e state;
    logic [7:0] last_code;
    logic       lshift_held;
    logic       rshift_held;
    logic       caps_held;
    logic [7:0] map_ascii;
    logic       map_hit;
    logic       is_repeat;
    logic       caps_code;

    ps2_keymap u_keymap (
        .code  (scan_data),
        .shift (shift),
        .caps  (caps),
        .ascii (map_ascii),
        .hit   (map_hit)
    );

    // Shift is the union of both held flags; repeat detection compares against the held key.
    always_comb begin
        shift     = lshift_held | rshift_held;
        is_repeat = (REPEAT_FILTER != 0) && key_down && (scan_data == last_code);
        caps_code = (CAPS_EN != 0) && (scan_data == CAPS);
    end

    // Prefix FSM plus all registered outputs; only strobed bytes move anything.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= ST_IDLE;
            ascii       <= 8'h00;
            ascii_valid <= 1'b0;
            key_down    <= 1'b0;
            key_count   <= '0;
            last_code   <= 8'h00;
            lshift_held <= 1'b0;
            rshift_held <= 1'b0;
            caps_held   <= 1'b0;
            caps        <= 1'b0;
        end else begin
            ascii_valid <= 1'b0;
            if (scan_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (scan_data == BRK_CODE) begin
                            state <= ST_BRK;
                        end else if (scan_data == EXT_CODE) begin
                            state <= ST_EXT;
                        end else if (is_shift_code(scan_data)) begin
                            if (scan_data == LSHIFT) lshift_held <= 1'b1;
                            else                     rshift_held <= 1'b1;
                        end else if (caps_code) begin
                            // Typematic repeats of Caps Lock must not re-toggle.
                            if (!caps_held) caps <= ~caps;
                            caps_held <= 1'b1;
                        end else if (map_hit && !is_repeat) begin
                            ascii       <= map_ascii;
                            ascii_valid <= 1'b1;
                            key_count   <= key_count + CNT_W'(1);
                            key_down    <= 1'b1;
                            last_code   <= scan_data;
                        end
                    end
                    ST_BRK: begin
                        state <= ST_IDLE;
                        if (scan_data == LSHIFT) lshift_held <= 1'b0;
                        if (scan_data == RSHIFT) rshift_held <= 1'b0;
                        if (caps_code)           caps_held   <= 1'b0;
                        // Only releasing the most recent key ends the held state.
                        if (scan_data == last_code) begin
                            key_down  <= 1'b0;
                            last_code <= 8'h00;
                        end
                    end
                    ST_EXT: begin
                        state <= (scan_data == BRK_CODE) ? ST_EXT_BRK : ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder: default instance plus a
// no-repeat-filter / no-caps / 4-bit-counter instance on the same byte stream.
module tb_ps2_ascii_decoder;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] scan_data;
    logic       scan_valid;

    logic [7:0] ascii, ascii_nf;
    logic       ascii_valid, ascii_valid_nf;
    logic       key_down, key_down_nf;
    logic [7:0] key_count;
    logic [3:0] key_count_nf;
    logic       shift, shift_nf;
    logic       caps, caps_nf;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses    = 0;
    int pulses_nf = 0;
    int pb, pb_nf;

    always #5 clk = ~clk;

    ps2_ascii_decoder #(.CNT_W(8), .REPEAT_FILTER(1), .CAPS_EN(1)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .scan_data   (scan_data),
        .scan_valid  (scan_valid),
        .ascii       (ascii),
        .ascii_valid (ascii_valid),
        .key_down    (key_down),
        .key_count   (key_count),
        .shift       (shift),
        .caps        (caps)
    );

    ps2_ascii_decoder #(.CNT_W(4), .REPEAT_FILTER(0), .CAPS_EN(0)) dut_nf (
        .clk         (clk),
        .clrn        (clrn),
        .scan_data   (scan_data),
        .scan_valid  (scan_valid),
        .ascii       (ascii_nf),
        .ascii_valid (ascii_valid_nf),
        .key_down    (key_down_nf),
        .key_count   (key_count_nf),
        .shift       (shift_nf),
        .caps        (caps_nf)
    );

    // Count ascii_valid pulses, sampled on the inactive edge.
    always @(negedge clk) begin
        if (ascii_valid)    pulses    <= pulses + 1;
        if (ascii_valid_nf) pulses_nf <= pulses_nf + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte for one rising edge; returns on the following falling edge.
    task automatic send(input logic [7:0] b);
        scan_data  = b;
        scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clrn       = 1'b0;
        scan_data  = 8'h00;
        scan_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ascii",  ascii, 8'h00);
        check("rst_valid",  ascii_valid, 1'b0);
        check("rst_keydn",  key_down, 1'b0);
        check("rst_count",  key_count, 8'd0);
        check("rst_shift",  shift, 1'b0);
        check("rst_caps",   caps, 1'b0);
        check("rst_state",  dut.state, ST_IDLE);
        clrn = 1'b1;
        @(negedge clk);

        // Single make: 'a' one cycle after the strobe, pulse lasts one cycle.
        pb = pulses; pb_nf = pulses_nf;
        send(8'h1C);
        check("a_ascii", ascii, 8'h61);
        check("a_valid", ascii_valid, 1'b1);
        check("a_count", key_count, 8'd1);
        check("a_keydn", key_down, 1'b1);
        tick();
        check("a_pulse_end", ascii_valid, 1'b0);
        check("a_hold", ascii, 8'h61);

        // Two more makes of the held key are typematic repeats, then release.
        send(8'h1C);
        check("rep_valid", ascii_valid, 1'b0);
        send(8'h1C);
        send(8'hF0);
        check("rep_keydn_held", key_down, 1'b1);
        send(8'h1C);
        check("rep_keydn_rel", key_down, 1'b0);
        tick();
        check("rep_pulses", pulses - pb, 1);
        check("rep_count", key_count, 8'd1);
        check("nf_pulses", pulses_nf - pb_nf, 3);
        check("nf_count", key_count_nf, 4'd3);
        check("nf_keydn_rel", key_down_nf, 1'b0);

        // Shift gives uppercase; Shift plus Caps cancel back to lowercase.
        send(8'h12);
        check("sh_on", shift, 1'b1);
        send(8'h1C);
        check("sh_A", ascii, 8'h41);
        send(8'hF0);
        send(8'h1C);
        send(8'h58);
        check("caps_on", caps, 1'b1);
        check("nf_caps_ignored", caps_nf, 1'b0);
        send(8'h58);
        check("caps_repeat_no_toggle", caps, 1'b1);
        send(8'hF0);
        send(8'h58);
        check("caps_break_keeps", caps, 1'b1);
        send(8'h1C);
        check("shcaps_a", ascii, 8'h61);
        check("shcaps_valid", ascii_valid, 1'b1);
        check("nf_sh_A", ascii_nf, 8'h41);
        send(8'hF0);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        check("sh_off", shift, 1'b0);

        // Caps alone uppercases letters but leaves digits alone.
        send(8'h32);
        check("caps_B", ascii, 8'h42);
        send(8'hF0);
        send(8'h32);
        send(8'h16);
        check("caps_digit1", ascii, 8'h31);
        send(8'hF0);
        send(8'h16);
        send(8'h59);
        send(8'h16);
        check("rsh_bang", ascii, 8'h21);
        send(8'hF0);
        send(8'h16);
        send(8'hF0);
        send(8'h59);
        send(8'h29);
        check("space", ascii, 8'h20);
        send(8'hF0);
        send(8'h29);
        send(8'h58);
        check("caps_off", caps, 1'b0);
        send(8'hF0);
        send(8'h58);
        check("count_mixed", key_count, 8'd7);

        // Unmapped make produces nothing.
        send(8'h76);
        check("unmapped_valid", ascii_valid, 1'b0);
        check("unmapped_count", key_count, 8'd7);

        // Extended make/break never emits and returns to IDLE.
        pb = pulses;
        send(8'hE0);
        check("ext_state", dut.state, ST_EXT);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        check("extbrk_state", dut.state, ST_EXT_BRK);
        send(8'h75);
        check("ext_idle", dut.state, ST_IDLE);
        tick();
        check("ext_pulses", pulses - pb, 0);
        check("ext_count", key_count, 8'd7);

        // Back-to-back strobes; releasing the older key keeps key_down.
        send(8'h1C);
        check("b2b_a", ascii, 8'h61);
        send(8'h32);
        check("b2b_b", ascii, 8'h62);
        check("b2b_valid", ascii_valid, 1'b1);
        check("b2b_count", key_count, 8'd9);
        send(8'hF0);
        send(8'h1C);
        check("brk_other_keydn", key_down, 1'b1);
        send(8'hF0);
        send(8'h32);
        check("brk_last_keydn", key_down, 1'b0);

        // Reset while a break prefix is pending discards it.
        send(8'hF0);
        check("pend_brk_state", dut.state, ST_BRK);
        pulse_reset();
        check("prst_state", dut.state, ST_IDLE);
        check("prst_count", key_count, 8'd0);
        send(8'h1C);
        check("prst_a", ascii, 8'h61);
        check("prst_valid", ascii_valid, 1'b1);
        check("prst_count1", key_count, 8'd1);

        // 256 emissions wrap the 8-bit counter back to 0.
        pulse_reset();
        pb = pulses;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            c = (i % 2 == 1) ? 8'h32 : 8'h1C;
            send(c);
            if (i == 254) check("wrap_255", key_count, 8'd255);
            send(8'hF0);
            send(c);
        end
        tick();
        check("wrap_zero", key_count, 8'd0);
        check("wrap_pulses", pulses - pb, 256);
        check("wrap_last_b", ascii, 8'h62);
        check("nf_wrap_zero", key_count_nf, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_ascii_decoder.md
PS2_ASCII_DECODER -- requirements
Module: ps2_ascii_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the keypress counter.
REQ-002 SHALL have parameter REPEAT_FILTER, default 1; when 1, typematic repeats of the held key are suppressed.
REQ-003 SHALL have parameter CAPS_EN, default 1; when 0, the Caps Lock code is ignored.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port clrn, input, 1, reset: one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port scan_data, input, 8, PS/2 scancode byte, sampled only when scan_valid=1.
REQ-007 SHALL have port scan_valid, input, 1, single-cycle strobe marking one received byte.
REQ-008 SHALL have port ascii, output, 8, last emitted ASCII code; holds until the next emission.
REQ-009 SHALL have port ascii_valid, output, 1, one-cycle pulse when ascii is updated.
REQ-010 SHALL have port key_down, output, 1, high while a mapped key is held.
REQ-011 SHALL have port key_count, output, CNT_W, count of emitted characters.
REQ-012 SHALL have port shift, output, 1, either Shift key held.
REQ-013 SHALL have port caps, output, 1, Caps Lock toggle state.

Function
REQ-014 SHALL implement FSM states IDLE, BRK, EXT and EXT_BRK; the FSM advances only on cycles with scan_valid=1.
REQ-015 IDLE transitions: 0xF0 -> BRK; 0xE0 -> EXT; any other byte is a make code and stays in IDLE.
REQ-016 BRK transitions: any byte is a break code -> IDLE.
REQ-017 EXT transitions: 0xF0 -> EXT_BRK; any other byte is ignored -> IDLE. Extended keys never emit.
REQ-018 EXT_BRK transitions: any byte -> IDLE, with no other effect.
REQ-019 Shift handling: a make of 0x12 or 0x59 sets the matching shift flag; the matching break clears it; shift = OR of the two flags.
REQ-020 Caps Lock handling: a make of 0x58 toggles caps only if 0x58 is not already held; the 0x58 break clears the held flag; the caps output is unchanged by the break.
REQ-021 Base map: letters a-z use the standard set-2 codes (0x1C->0x61 ... 0x1A->0x7A); digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to 0x30..0x39; 0x29->0x20; 0x5A->0x0D; every other code is unmapped.
REQ-022 Letters are uppercase (subtract 0x20) when shift XOR caps is true.
REQ-023 Digits with shift map to ")!@#$%^&*(" in 0..9 order; caps SHALL NOT affect digits.
REQ-024 A mapped make code that is not a repeat SHALL, on the next cycle: drive ascii, pulse ascii_valid, increment key_count, set key_down, and latch last_code.
REQ-025 Repeat rule: when REPEAT_FILTER=1 and key_down=1 and code==last_code, there SHALL be no emission and no count change; when REPEAT_FILTER=0, every make of a mapped code emits.
REQ-026 A break whose code equals last_code SHALL clear key_down and last_code; any other break leaves both unchanged.
REQ-027 An unmapped make or a shift/caps make SHALL NOT emit or count.
REQ-028 key_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-029 Latency from scan_valid to ascii_valid SHALL be exactly 1 cycle; back-to-back strobes are accepted every cycle.

Reset
REQ-030 clrn=0 SHALL force state IDLE and set ascii=0x00, ascii_valid=0, key_down=0, key_count=0, shift=0, caps=0, last_code=0x00 and both held flags to 0.
REQ-031 Reset asserted in any non-IDLE state SHALL discard the pending prefix; the first byte after release is decoded from IDLE.

Structure
REQ-032 A shared package ps2_pkg SHALL hold the FSM state typedef and the constants BRK_CODE=0xF0, EXT_CODE=0xE0, LSHIFT=0x12, RSHIFT=0x59 and CAPS=0x58.
REQ-033 A combinational sub-module ps2_keymap (code, shift, caps -> ascii, hit) SHALL hold the map.

Verification
REQ-034 Bench SHALL check: 0x1C -> ascii=0x61, ascii_valid pulses 1 cycle later, key_count=1.
REQ-035 Bench SHALL check: 0x12, 0x1C, then 0x58,0xF0,0x58, 0x1C -> 0x61, i.e. shift and caps cancel.
REQ-036 Bench SHALL check: with REPEAT_FILTER=1, 0x1C x3 then 0xF0,0x1C -> exactly one pulse, with key_down 1->0 after the break.
REQ-037 Bench SHALL check: 0xE0,0x75,0xE0,0xF0,0x75 -> no pulse and FSM back in IDLE.
REQ-038 Bench SHALL check: with CNT_W=8, 256 distinct emissions -> key_count returns to 0.
REQ-039 Bench SHALL check: 0xF0 followed by clrn pulse, then 0x1C -> emits 0x61; the 0x1C is not treated as a break.
